// File: rtl/ring_vc_arbiter.sv
// ring_vc_arbiter: output-channel arbiter for one ring router port.
// Two requesters (upstream pass-through and local NIC injection) share one
// outgoing link through two single-entry virtual-channel buffers. A
// free-running polarity bit selects which VC fills and which drains each
// cycle, so one load and one unload can happen in the same cycle.
module ring_vc_arbiter #(
  parameter int DW     = 64,
  parameter int VC_BIT = 63
) (
  input  logic          clk,
  input  logic          reset,
  output logic          polarity,
  input  logic          in0_si,
  output logic          in0_ri,
  input  logic [DW-1:0] in0_di,
  input  logic          in1_si,
  output logic          in1_ri,
  input  logic [DW-1:0] in1_di,
  output logic          out_so,
  input  logic          out_ro,
  output logic [DW-1:0] out_do
);

  logic          polarity_q;
  logic          polarity_d;
  logic [1:0]    valid_q;
  logic [1:0]    valid_d;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic [1:0]    rrPtr_q;
  logic [1:0]    rrPtr_d;

  logic          fillVc;
  logic          drainVc;
  logic          fillFree;
  logic          elig0;
  logic          elig1;
  logic          grant0;
  logic          grant1;
  logic          fillFire;
  logic [DW-1:0] fillData;
  logic          drainFire;

  assign fillVc  = polarity_q;
  assign drainVc = ~polarity_q;

  // Work out which requester (if any) wins the filling VC this cycle
  always_comb begin
    fillFree = ~valid_q[fillVc];
    elig0    = in0_si & (in0_di[VC_BIT] == fillVc) & fillFree;
    elig1    = in1_si & (in1_di[VC_BIT] == fillVc) & fillFree;
    grant0   = elig0 & (~elig1 | ~rrPtr_q[fillVc]);
    grant1   = elig1 & (~elig0 |  rrPtr_q[fillVc]);
    fillFire = grant0 | grant1;
    fillData = grant0 ? in0_di : in1_di;
  end

  // Grants are suppressed while reset is held so no handshake can complete
  always_comb begin
    in0_ri = grant0 & reset;
    in1_ri = grant1 & reset;
  end

  // Present the draining VC downstream; data reads as zero when empty
  always_comb begin
    out_so    = valid_q[drainVc];
    out_do    = valid_q[drainVc] ? buf_q[drainVc] : '0;
    drainFire = valid_q[drainVc] & out_ro;
    polarity  = polarity_q;
  end

  // Next-state for buffers and round-robin pointers: fill and drain touch different VCs
  always_comb begin
    polarity_d = ~polarity_q;
    valid_d    = valid_q;
    rrPtr_d    = rrPtr_q;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    if (fillFire) begin
      buf_d[fillVc]   = fillData;
      valid_d[fillVc] = 1'b1;
      rrPtr_d[fillVc] = grant0;
    end
    if (drainFire) begin
      valid_d[drainVc] = 1'b0;
    end
  end

  // State register; reset discards any buffered packets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_q <= 1'b0;
      valid_q    <= 2'b00;
      rrPtr_q    <= 2'b00;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      polarity_q <= polarity_d;
      valid_q    <= valid_d;
      rrPtr_q    <= rrPtr_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

endmodule

// File: tb/tb_ring_vc_arbiter.sv
// Testbench for ring_vc_arbiter: directed vector table, hand-written reset
// sequence, and randomized traffic against a reference model.
module tb_ring_vc_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          in0_si, in0_ri, in1_si, in1_ri;
  logic [DW-1:0] in0_di, in1_di;
  logic          out_so, out_ro;
  logic [DW-1:0] out_do;

  int checks = 0;
  int errors = 0;

  ring_vc_arbiter #(.DW(64), .VC_BIT(63)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .in0_si(in0_si), .in0_ri(in0_ri), .in0_di(in0_di),
    .in1_si(in1_si), .in1_ri(in1_ri), .in1_di(in1_di),
    .out_so(out_so), .out_ro(out_ro), .out_do(out_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          s0;
    logic [63:0]   d0;
    logic          s1;
    logic [63:0]   d1;
    logic          ro;
    logic          pol;
    logic          ri0;
    logic          ri1;
    logic          so;
    logic [63:0]   dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic rst, logic s0, logic [63:0] d0, logic s1, logic [63:0] d1,
                                 logic ro, logic pol, logic ri0, logic ri1, logic so, logic [63:0] dout);
    vec_t v;
    v.rst = rst; v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1; v.ro = ro;
    v.pol = pol; v.ri0 = ri0; v.ri1 = ri1; v.so = so; v.dout = dout;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic s0, input logic [63:0] d0,
                               input logic s1, input logic [63:0] d1, input logic ro);
    reset  = rst;
    in0_si = s0;
    in0_di = d0;
    in1_si = s1;
    in1_di = d1;
    out_ro = ro;
  endtask

  task automatic checkAll(input string tag, input logic ePol, input logic eRi0, input logic eRi1,
                          input logic eSo, input logic [63:0] eDo);
    checkOutput({tag, " polarity"}, {63'b0, polarity}, {63'b0, ePol});
    checkOutput({tag, " in0_ri"},   {63'b0, in0_ri},   {63'b0, eRi0});
    checkOutput({tag, " in1_ri"},   {63'b0, in1_ri},   {63'b0, eRi1});
    checkOutput({tag, " out_so"},   {63'b0, out_so},   {63'b0, eSo});
    checkOutput({tag, " out_do"},   out_do,            eDo);
  endtask

  // Reference model state for the random phase
  bit          mPol;
  bit          mValid [2];
  logic [63:0] mData [2];
  bit          mRr [2];
  bit          pend [2];
  logic [63:0] pdata [2];

  initial begin
    localparam logic [63:0] P01 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] P02 = 64'h8000_0000_0000_0002;
    localparam logic [63:0] Z   = 64'h0;
    int accepted;
    int delivered;

    // rst s0 d0 s1 d1 ro | pol ri0 ri1 so do
    addVec(0, 1, Z,    1, Z,    1, 0, 0, 0, 0, Z);
    addVec(0, 1, Z,    1, Z,    1, 0, 0, 0, 0, Z);
    addVec(0, 1, Z,    1, Z,    1, 0, 0, 0, 0, Z);
    addVec(1, 0, Z,    1, 64'hA5, 1, 0, 0, 1, 0, Z);
    addVec(1, 0, Z,    0, Z,    1, 1, 0, 0, 1, 64'hA5);
    addVec(1, 1, P01,  0, Z,    1, 0, 0, 0, 0, Z);
    addVec(1, 1, P01,  0, Z,    1, 1, 1, 0, 0, Z);
    addVec(1, 1, P01,  1, P02,  1, 0, 0, 0, 1, P01);
    addVec(1, 1, P01,  1, P02,  1, 1, 0, 1, 0, Z);
    addVec(1, 1, P01,  1, P02,  1, 0, 0, 0, 1, P02);
    addVec(1, 1, P01,  1, P02,  1, 1, 1, 0, 0, Z);
    addVec(1, 1, P01,  1, P02,  1, 0, 0, 0, 1, P01);
    addVec(1, 1, P01,  1, P02,  1, 1, 0, 1, 0, Z);
    addVec(1, 0, Z,    0, Z,    1, 0, 0, 0, 1, P02);
    addVec(1, 0, Z,    0, Z,    1, 1, 0, 0, 0, Z);
    addVec(1, 1, 64'h33, 0, Z,  1, 0, 1, 0, 0, Z);
    addVec(1, 0, Z,    1, 64'h44, 0, 1, 0, 0, 1, 64'h33);
    addVec(1, 0, Z,    1, 64'h44, 0, 0, 0, 0, 0, Z);
    addVec(1, 0, Z,    1, 64'h44, 0, 1, 0, 0, 1, 64'h33);
    addVec(1, 0, Z,    1, 64'h44, 0, 0, 0, 0, 0, Z);
    addVec(1, 0, Z,    1, 64'h44, 0, 1, 0, 0, 1, 64'h33);
    addVec(1, 0, Z,    1, 64'h44, 0, 0, 0, 0, 0, Z);
    addVec(1, 0, Z,    1, 64'h44, 1, 1, 0, 0, 1, 64'h33);
    addVec(1, 0, Z,    1, 64'h44, 1, 0, 0, 1, 0, Z);
    addVec(1, 0, Z,    0, Z,    1, 1, 0, 0, 1, 64'h44);
    addVec(1, 0, Z,    0, Z,    1, 0, 0, 0, 0, Z);
    addVec(1, 0, Z,    0, Z,    1, 1, 0, 0, 0, Z);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].s0, vecs[i].d0, vecs[i].s1, vecs[i].d1, vecs[i].ro);
      #2;
      checkAll($sformatf("vec%0d", i), vecs[i].pol, vecs[i].ri0, vecs[i].ri1, vecs[i].so, vecs[i].dout);
      @(posedge clk);
      #1;
    end

    // Fill both buffers under backpressure, then reset asynchronously mid-cycle
    applyStimulus(1, 1, 64'h55, 0, Z, 0);
    #2; checkAll("fillA", 0, 1, 0, 0, Z);
    @(posedge clk); #1;
    applyStimulus(1, 0, Z, 1, 64'h8000_0000_0000_0066, 0);
    #2; checkAll("fillB", 1, 0, 1, 1, 64'h55);
    @(posedge clk); #1;
    applyStimulus(1, 0, Z, 0, Z, 0);
    #2; checkAll("fillC", 0, 0, 0, 1, 64'h8000_0000_0000_0066);
    applyStimulus(0, 1, 64'h77, 1, 64'h88, 1);
    #1; checkAll("midReset", 0, 0, 0, 0, Z);
    @(posedge clk); #1;
    checkAll("inReset", 0, 0, 0, 0, Z);
    @(posedge clk); #1;
    applyStimulus(1, 1, 64'h77, 1, 64'h88, 1);
    #2; checkAll("postRst0", 0, 1, 0, 0, Z);
    @(posedge clk); #1;
    applyStimulus(1, 0, Z, 1, 64'h88, 1);
    #2; checkAll("postRst1", 1, 0, 0, 1, 64'h77);
    @(posedge clk); #1;
    applyStimulus(1, 0, Z, 1, 64'h88, 1);
    #2; checkAll("postRst2", 0, 0, 1, 0, Z);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    applyStimulus(0, 0, Z, 0, Z, 0);
    @(posedge clk); #1;
    mPol = 0;
    for (int v = 0; v < 2; v++) begin
      mValid[v] = 0; mData[v] = '0; mRr[v] = 0; pend[v] = 0; pdata[v] = '0;
    end
    accepted  = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit ro, e0, e1, g0, g1, eSo;
      int fp, dp;
      logic [63:0] eDo;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k]  = 1;
          pdata[k] = {$urandom, $urandom};
        end
      end
      ro = ($urandom_range(0, 3) != 0);
      applyStimulus(1, pend[0], pdata[0], pend[1], pdata[1], ro);
      fp  = mPol ? 1 : 0;
      dp  = 1 - fp;
      e0  = pend[0] && (pdata[0][63] == mPol) && !mValid[fp];
      e1  = pend[1] && (pdata[1][63] == mPol) && !mValid[fp];
      g0  = e0 && (!e1 || !mRr[fp]);
      g1  = e1 && (!e0 || mRr[fp]);
      eSo = mValid[dp];
      eDo = eSo ? mData[dp] : 64'h0;
      #2;
      checkAll($sformatf("rnd%0d", cyc), mPol, g0, g1, eSo, eDo);
      @(posedge clk); #1;
      if (g0 || g1) begin
        mData[fp]  = g0 ? pdata[0] : pdata[1];
        mValid[fp] = 1;
        mRr[fp]    = g0;
        if (g0) pend[0] = 0; else pend[1] = 0;
        accepted++;
      end
      if (eSo && ro) begin
        mValid[dp] = 0;
        delivered++;
      end
      mPol = !mPol;
    end
    checkOutput("conservation", 64'(accepted),
                64'(delivered + (mValid[0] ? 1 : 0) + (mValid[1] ? 1 : 0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
